// File: rtl/nand_share_scheduler_pkg.sv
// Shared types and defaults for the NAND-gate sharing scheduler.
package nand_share_scheduler_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_SETTLE = 2;
    localparam int DEF_WINDOW = 64;
    localparam int DEF_BUDGET = 16;
    localparam int DEF_CNT_W  = 16;

    // Pointer is sized for the largest supported requester count (8).
    localparam int PTR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETTLE   = 2'd1,
        S_CAPTURE  = 2'd2,
        S_THROTTLE = 2'd3
    } state_t;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [7:0] oh);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = PTR_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/nand_share_scheduler_if.sv
// Requester handshake plus shared-gate drive/sense bundle.
interface nand_share_scheduler_if #(
    parameter int NREQ  = nand_share_scheduler_pkg::DEF_NREQ,
    parameter int CNT_W = nand_share_scheduler_pkg::DEF_CNT_W
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  op_a;
    logic [NREQ-1:0]  op_b;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             y_out;
    logic             gate_a;
    logic             gate_b;
    logic             gate_y;
    logic             throttled;
    logic [CNT_W-1:0] total_toggles;

    // Scheduler side
    modport slave (
        input  req, op_a, op_b, gate_y,
        output gnt, done, y_out, gate_a, gate_b, throttled, total_toggles
    );

    // Requesters and gate side
    modport master (
        output req, op_a, op_b, gate_y,
        input  gnt, done, y_out, gate_a, gate_b, throttled, total_toggles
    );
endinterface

// File: rtl/nand_share_scheduler_rr_picker.sv
// Combinational round-robin pick: first asserted request at/after the pointer, wrapping.
module rr_picker
    import nand_share_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  win_o,
    output logic             valid_o
);
    localparam int IW = $clog2(NREQ);

    int          idx;
    logic [IW-1:0] sel;
    logic        found;

    // Scan NREQ positions starting at the pointer, keep the first hit.
    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = IW'(idx);
            if (!found && req_i[sel]) begin
                win_o[sel] = 1'b1;
                found      = 1'b1;
            end
        end
        valid_o = found;
    end
endmodule

// File: rtl/nand_share_scheduler.sv
// Round-robin scheduler sharing one 2-input NAND among NREQ requesters,
// with a per-window output-toggle budget that throttles grants.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  S_IDLE     | arbitrate; latch winner operands onto the gate
//  S_SETTLE   | hold gate inputs SETTLE cycles (covers gate tpd)
//  S_CAPTURE  | sample gate_y, pulse done, count toggle, advance pointer
//  S_THROTTLE | toggle budget spent; no grants until window wraps
module nand_share_scheduler
    import nand_share_scheduler_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int SETTLE = DEF_SETTLE,
    parameter int WINDOW = DEF_WINDOW,
    parameter int BUDGET = DEF_BUDGET,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nand_share_scheduler_if.slave bus
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int WW = $clog2(WINDOW);
    localparam int TW = $clog2(BUDGET + 1) + 1;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             y_q, y_d;
    logic             ga_q, ga_d;
    logic             gb_q, gb_d;
    logic             thr_q, thr_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic             last_y_q, last_y_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WW-1:0]    win_q, win_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    logic [NREQ-1:0]  pick_win;
    logic             pick_valid;
    logic             wrap;
    logic [TW-1:0]    tcnt_base;
    logic [PTR_W-1:0] win_idx;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    assign wrap    = (win_q == WW'(WINDOW - 1));
    assign win_idx = onehot_to_idx(8'(gnt_q));

    // Next-state logic: FSM, settle timer, free-running window, toggle counters.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        y_d       = y_q;
        ga_d      = ga_q;
        gb_d      = gb_q;
        thr_d     = thr_q;
        tot_d     = tot_q;
        last_y_d  = last_y_q;
        ptr_d     = ptr_q;
        settle_d  = settle_q;
        win_d     = wrap ? '0 : win_q + 1'b1;
        // Window clear happens before any toggle counted in the same cycle.
        tcnt_base = wrap ? '0 : tcnt_q;
        tcnt_d    = tcnt_base;

        case (state_q)
            S_IDLE: begin
                if (pick_valid && !thr_q) begin
                    gnt_d    = pick_win;
                    ga_d     = |(bus.op_a & pick_win);
                    gb_d     = |(bus.op_b & pick_win);
                    settle_d = SW'(SETTLE - 1);
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d = S_CAPTURE;
                else                settle_d = settle_q - 1'b1;
            end
            S_CAPTURE: begin
                y_d    = bus.gate_y;
                done_d = gnt_q;
                gnt_d  = '0;
                if (win_idx == PTR_W'(NREQ - 1)) ptr_d = '0;
                else                             ptr_d = win_idx + 1'b1;
                if (bus.gate_y != last_y_q) begin
                    tcnt_d   = tcnt_base + 1'b1;
                    last_y_d = bus.gate_y;
                    if (tot_q != {CNT_W{1'b1}}) tot_d = tot_q + 1'b1;
                end
                if (tcnt_d >= TW'(BUDGET)) begin
                    state_d = S_THROTTLE;
                    thr_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_THROTTLE: begin
                if (wrap) begin
                    state_d = S_IDLE;
                    thr_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; last_y resets to NAND(0,0)=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            y_q      <= 1'b0;
            ga_q     <= 1'b0;
            gb_q     <= 1'b0;
            thr_q    <= 1'b0;
            tot_q    <= '0;
            last_y_q <= 1'b1;
            ptr_q    <= '0;
            settle_q <= '0;
            win_q    <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            y_q      <= y_d;
            ga_q     <= ga_d;
            gb_q     <= gb_d;
            thr_q    <= thr_d;
            tot_q    <= tot_d;
            last_y_q <= last_y_d;
            ptr_q    <= ptr_d;
            settle_q <= settle_d;
            win_q    <= win_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.done          = done_q;
    assign bus.y_out         = y_q;
    assign bus.gate_a        = ga_q;
    assign bus.gate_b        = gb_q;
    assign bus.throttled     = thr_q;
    assign bus.total_toggles = tot_q;
endmodule
